ps2_host_rx: RTL
================

Name: ps2_host_rx

Overview:
- PS/2 receiver that runs on the core side.
- Decodes the ps2_kbd_clk/ps2_kbd_data or ps2_mouse_clk/ps2_mouse_data line pairs driven by the IO block's PS/2 emulation transmitters into bytes.
- Received bytes go into a small FIFO that keyboard and mouse consumers read with a valid/ack handshake.
- Line inputs are synchronised and glitch-filtered, frames are checked for framing and odd parity, and a stalled frame is abandoned by timeout.

Parameters:
- FIFO_BITS, 3, log2 of FIFO depth (default 8 entries).
- FILTER, 4, clk_sys cycles a synchronised line must be stable before the filtered value changes (range 1..255).
- TIMEOUT, 4096, clk_sys cycles without a falling ps2 clock edge mid-frame before the frame is aborted (range 16..2^20).

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  PS/2 clock line, asynchronous to clk_sys.
- ps2_data  in  1  PS/2 data line, asynchronous to clk_sys.
- rd_data  out  8  FIFO head byte; valid only while rd_valid=1.
- rd_valid  out  1  FIFO not empty.
- rd_ack  in  1  pops the head when rd_valid=1; ignored when rd_valid=0.
- busy  out  1  frame in progress (state != IDLE).
- parity_err  out  1  one-cycle pulse: frame discarded for bad parity.
- frame_err  out  1  one-cycle pulse: bad stop bit or timeout.
- overflow  out  1  one-cycle pulse: good byte dropped because the FIFO was full.

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE; filtered lines 1; timer 0.
- Input path:
  - 2-FF synchroniser per line.
  - Filter: the filtered value takes the synced value after FILTER consecutive cycles of mismatch. A match resets the count.
  - A falling edge is filtered clk going 1->0, registered. That cycle is "fe".
  - Data is sampled from filtered data in the fe cycle.
- State machine (advances on fe only):
  - IDLE: data=0 -> DATA with bit count 0. data=1 -> stay in IDLE (spurious edge, no error).
  - DATA: shift in LSB first; after 8 bits -> PARITY.
  - PARITY: latch the parity bit -> STOP.
  - STOP: always -> IDLE. Evaluate in priority order:
    1. Stop bit = 0 -> frame_err.
    2. Otherwise parity bit != ~^byte -> parity_err.
    3. Otherwise push the byte to the FIFO.
- Latency: rd_valid rises the cycle after the stop-bit fe cycle when the FIFO was empty. rd_data equals the byte in that same cycle.
- Timeout:
  - The timer clears on every fe and counts while state != IDLE.
  - On reaching TIMEOUT: state -> IDLE, frame_err pulses, and the partial byte is discarded.
  - The timer is held at 0 in IDLE.
- FIFO:
  - Circular buffer, wptr/rptr of FIFO_BITS+1 bits; full when pointers differ only in the MSB.
  - Push while full with no same-cycle pop -> byte dropped, overflow pulses, contents unchanged.
  - Push and pop in the same cycle is always legal, full or empty-after-pop-not-allowed: when empty, rd_ack is ignored, so only the push happens.
  - Pointers wrap modulo 2^(FIFO_BITS+1).
- Error pulses are exactly 1 cycle. At most one of the three pulses is asserted per frame.
- Asynchronous reset mid-frame aborts the frame immediately and empties the FIFO. The next frame must begin with a fresh start bit.

Optional Feature:
- Macro: PS2_HOST_RX_SCANCODE_EN.
- Defined: adds outputs key_code[7:0], key_ext, key_release, key_strobe. A decoder watches FIFO pushes:
  - 0xE0 sets a pending ext flag.
  - 0xF0 sets a pending release flag.
  - Any other byte produces a one-cycle key_strobe with key_code=byte and key_ext/key_release equal to the pending flags, then clears both flags.
  - The decoder runs in the push cycle; the event is registered, so key_strobe appears 1 cycle after the stop-bit fe.
  - Prefix bytes are still pushed to the FIFO. A dropped (overflow) byte is still decoded.
  - Reset clears the flags and outputs.
- Undefined: the ports and the logic are absent; raw FIFO only.

Test Plan:
- Send frame 0x1C (start 0, data LSB first, parity 0, stop 1) at PS/2 clock = 200 clk_sys cycles -> rd_valid=1 and rd_data=0x1C 1 cycle after the stop fe; rd_ack pops it and rd_valid=0 next cycle.
- Send 0x1C with parity 1 -> parity_err pulses once; FIFO stays empty. Send 0xF0 with parity 1 and stop 0 -> frame_err only.
- Send 9 good bytes 0x01..0x09 with no rd_ack (FIFO_BITS=3) -> 8 bytes stored, overflow pulse on 0x09; reading yields 0x01..0x08. Repeat with rd_ack on the 9th push cycle -> no overflow.
- Send start plus 4 data bits then stop the clock for TIMEOUT+10 cycles -> frame_err at TIMEOUT and busy=0; a following 0x5A frame is received intact.
- Inject 2-cycle glitches on ps2_clk (FILTER=4) in IDLE and mid-frame -> no extra bits sampled; 0x5A is received correctly. Assert reset mid-frame -> outputs 0, FIFO empty.
- With PS2_HOST_RX_SCANCODE_EN: send E0,F0,75 -> one key_strobe with key_code=0x75, key_ext=1, key_release=1; then send 1C -> key_strobe with ext=0, release=0.

Source files
------------

// File: rtl/ps2_host_rx.sv
// PS/2 host-side receiver: synchronise and filter the line pair, decode 11-bit frames, and queue bytes in a FIFO.
// Optional make/break scancode decoder enabled by defining PS2_HOST_RX_SCANCODE_EN.
module ps2_host_rx #(
  parameter int FIFO_BITS = 3,
  parameter int FILTER    = 4,
  parameter int TIMEOUT   = 4096
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ack,
  output logic       busy,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
`ifdef PS2_HOST_RX_SCANCODE_EN
  ,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_strobe
`endif
);

  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int DEPTH = 1 << FIFO_BITS;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Line conditioning: index 0 is the clock line, index 1 the data line.
  logic [1:0]      sync_a, sync_b, filt;
  logic [1:0][7:0] flt_cnt;
  logic            filt_clk_d;
  logic            fe;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync_a     <= 2'b11;
      sync_b     <= 2'b11;
      filt       <= 2'b11;
      flt_cnt    <= '0;
      filt_clk_d <= 1'b1;
      fe         <= 1'b0;
    end else begin
      sync_a <= {ps2_data, ps2_clk};
      sync_b <= sync_a;
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == filt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == 8'(FILTER - 1)) begin
          filt[i]    <= sync_b[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 8'd1;
        end
      end
      filt_clk_d <= filt[0];
      fe         <= filt_clk_d & ~filt[0];
    end
  end

  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_q, par_d;
  logic [TW-1:0]   timer_q;
  logic            timeout;
  logic            push, perr_c, ferr_c;

  assign timeout = (state_q != S_IDLE) && !fe && (timer_q == TW'(TIMEOUT - 1));
  assign busy    = (state_q != S_IDLE);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    push      = 1'b0;
    perr_c    = 1'b0;
    ferr_c    = 1'b0;
    if (timeout) begin
      state_d = S_IDLE;
      ferr_c  = 1'b1;
    end else if (fe) begin
      unique case (state_q)
        S_IDLE: begin
          if (!filt[1]) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        S_DATA: begin
          shreg_d   = {filt[1], shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = filt[1];
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!filt[1])                ferr_c = 1'b1;
          else if (par_q != ~^shreg_q) perr_c = 1'b1;
          else                         push   = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      // Timer measures the gap since the last falling edge of an active frame.
      if (fe || state_d == S_IDLE) timer_q <= '0;
      else                         timer_q <= timer_q + TW'(1);
    end
  end

  // FIFO with one extra pointer bit to tell full from empty.
  logic [7:0]         mem [DEPTH];
  logic [FIFO_BITS:0] wptr, rptr;
  logic               empty, full, pop, wr_en, ovf_c;

  assign empty   = (wptr == rptr);
  assign full    = ((wptr ^ rptr) == {1'b1, {FIFO_BITS{1'b0}}});
  assign pop     = rd_ack & ~empty;
  assign wr_en   = push & (~full | pop);
  assign ovf_c   = push & full & ~pop;
  assign rd_valid = ~empty;
  assign rd_data  = empty ? 8'h00 : mem[rptr[FIFO_BITS-1:0]];

  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wptr[FIFO_BITS-1:0]] <= shreg_q;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      parity_err <= perr_c;
      frame_err  <= ferr_c;
      overflow   <= ovf_c;
    end
  end

`ifdef PS2_HOST_RX_SCANCODE_EN
  // Prefix bytes arm flags that qualify the next non-prefix byte; overflowed bytes still count.
  logic ext_pend, rel_pend;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ext_pend    <= 1'b0;
      rel_pend    <= 1'b0;
      key_code    <= '0;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
      key_strobe  <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (push) begin
        if (shreg_q == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (shreg_q == 8'hF0) begin
          rel_pend <= 1'b1;
        end else begin
          key_strobe  <= 1'b1;
          key_code    <= shreg_q;
          key_ext     <= ext_pend;
          key_release <= rel_pend;
          ext_pend    <= 1'b0;
          rel_pend    <= 1'b0;
        end
      end
    end
  end
`endif

endmodule
